// File: rtl/student_ram8_bank_pkg.sv
// Shared constants and FSM encoding for the 8-word register bank and its decoder.
package student_ram8_bank_pkg;

    localparam int RAM8_DEPTH = 8;
    localparam int RAM8_AW    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram8_state_t;

endpackage

// File: rtl/student_ram8_bank_dmux8way.sv
// One-to-eight demultiplexer: routes a single strobe onto the per-word load enable picked by sel.
module student_dmux8way
    import student_ram8_bank_pkg::*;
(
    input  logic                  in,
    input  logic [RAM8_AW-1:0]    sel,
    output logic [RAM8_DEPTH-1:0] out
);

    always_comb begin
        out      = '0;
        out[sel] = in;
    end

endmodule

// File: rtl/student_ram8_bank.sv
// 8-word register bank with a valid/ready write port, registered read port,
// per-word written flags and an 8-cycle clear-all sweep.
module student_ram8_bank
    import student_ram8_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [RAM8_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [RAM8_AW-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_written,
    input  logic               clr_req,
    output logic               busy
);

    ram8_state_t           state;
    ram8_state_t           state_next;
    logic [RAM8_AW-1:0]    cnt;
    logic [WIDTH-1:0]      mem [RAM8_DEPTH];
    logic [RAM8_DEPTH-1:0] written;
    logic [RAM8_DEPTH-1:0] load;
    logic                  wr_fire;
    logic                  clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (cnt == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:    wr_ready = !clr_req;
            CLEAR:   busy = 1'b1;
            default: wr_ready = 1'b0;
        endcase
    end

    assign clearing = (state == CLEAR);
    assign wr_fire  = wr_valid && wr_ready;

    // The sweep reuses the write decoder so only one word is ever loaded per edge.
    student_dmux8way u_dmux (
        .in  (wr_fire | clearing),
        .sel (clearing ? cnt : wr_addr),
        .out (load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clearing) begin
            cnt <= cnt + 1'b1;
        end else if (clr_req) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM8_DEPTH; i++) begin
                mem[i] <= '0;
            end
            written <= '0;
        end else begin
            for (int i = 0; i < RAM8_DEPTH; i++) begin
                if (load[i]) begin
                    mem[i]     <= clearing ? '0 : wr_data;
                    written[i] <= !clearing;
                end
            end
        end
    end

    // Samples the pre-edge contents, so a same-address write is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_written <= 1'b0;
        end else begin
            rd_data    <= mem[rd_addr];
            rd_written <= written[rd_addr];
        end
    end

endmodule

// File: tb/tb_student_ram8_bank.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an array-based model of the bank.
module tb_student_ram8_bank;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_addr  = '0;
    logic [15:0] wr_data  = '0;
    logic [2:0]  rd_addr  = '0;
    logic        clr_req  = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_written;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [8]     = '{default: '0};
    bit          m_written [8] = '{default: 1'b0};
    int          m_left        = 0;
    logic [15:0] m_rd_data     = '0;
    bit          m_rd_written  = 1'b0;

    student_ram8_bank #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_written (rd_written),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // m_left counts words still to be wiped; word (8 - m_left) is the one wiped on the next edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i]     = '0;
                m_written[i] = 1'b0;
            end
            m_left       = 0;
            m_rd_data    = '0;
            m_rd_written = 1'b0;
        end else begin
            m_rd_data    = m_mem[rd_addr];
            m_rd_written = m_written[rd_addr];
            if (m_left > 0) begin
                m_mem[8 - m_left]     = '0;
                m_written[8 - m_left] = 1'b0;
                m_left--;
            end else if (clr_req) begin
                m_left = 8;
            end else if (wr_valid) begin
                m_mem[wr_addr]     = wr_data;
                m_written[wr_addr] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_rd_data", 32'(rd_data), 32'(m_rd_data));
        checkOutput("model_rd_written", 32'(rd_written), 32'(m_rd_written));
        checkOutput("model_busy", 32'(busy), 32'(m_left > 0));
        checkOutput("model_wr_ready", 32'(wr_ready), 32'((m_left == 0) && !clr_req));
    end

    task automatic applyStimulus(input bit v, input logic [2:0] a, input logic [15:0] d,
                                 input logic [2:0] r, input bit c);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        rd_addr  = r;
        clr_req  = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_wr_ready", 32'(wr_ready), 32'(1));

        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, 3'd0, 16'h0, 3'(a), 1'b0);
            tick();
            checkOutput("reset_rd_data", 32'(rd_data), 32'(0));
            checkOutput("reset_rd_written", 32'(rd_written), 32'(0));
        end

        applyStimulus(1'b1, 3'd3, 16'hBEEF, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 1'b0);
        tick();
        checkOutput("beef_rd_data", 32'(rd_data), 32'h0000_BEEF);
        checkOutput("beef_rd_written", 32'(rd_written), 32'(1));
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd2, 1'b0);
        tick();
        checkOutput("addr2_rd_data", 32'(rd_data), 32'(0));
        checkOutput("addr2_rd_written", 32'(rd_written), 32'(0));

        applyStimulus(1'b1, 3'd5, 16'h1234, 3'd5, 1'b0);
        tick();
        checkOutput("rdw_old_data", 32'(rd_data), 32'(0));
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd5, 1'b0);
        tick();
        checkOutput("rdw_new_data", 32'(rd_data), 32'h0000_1234);
        checkOutput("rdw_new_written", 32'(rd_written), 32'(1));

        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 3'(k), 16'h1000 + 16'(k), 3'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 1'b1);
        checkOutput("clr_wr_ready", 32'(wr_ready), 32'(0));
        tick();
        // Reading word e on sweep edge e still returns its pre-clear value.
        for (int e = 0; e < 8; e++) begin
            applyStimulus(1'b1, 3'(e), 16'hFFFF, 3'(e), 1'b1);
            checkOutput("sweep_busy", 32'(busy), 32'(1));
            checkOutput("sweep_wr_ready", 32'(wr_ready), 32'(0));
            tick();
            checkOutput("sweep_old_data", 32'(rd_data), 32'h1000 + 32'(e));
        end
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 1'b0);
        checkOutput("sweep_end_busy", 32'(busy), 32'(0));
        checkOutput("sweep_end_wr_ready", 32'(wr_ready), 32'(1));
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, 3'd0, 16'h0, 3'(a), 1'b0);
            tick();
            checkOutput("cleared_rd_data", 32'(rd_data), 32'(0));
            checkOutput("cleared_rd_written", 32'(rd_written), 32'(0));
        end

        applyStimulus(1'b1, 3'd1, 16'h5555, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd1, 16'hAAAA, 3'd1, 1'b1);
        checkOutput("clr_wins_wr_ready", 32'(wr_ready), 32'(0));
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd1, 1'b0);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checkOutput("sweep_length", 32'(n), 32'(8));
        tick();
        checkOutput("clr_wins_rd_data", 32'(rd_data), 32'(0));
        checkOutput("clr_wins_rd_written", 32'(rd_written), 32'(0));

        applyStimulus(1'b1, 3'd3, 16'h3333, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd6, 16'h6666, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 1'b0);
        repeat (4) tick();
        checkOutput("midclr_busy", 32'(busy), 32'(1));
        checkOutput("midclr_rd_data", 32'(rd_data), 32'h0000_3333);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", 32'(busy), 32'(0));
        checkOutput("async_rd_data", 32'(rd_data), 32'(0));
        checkOutput("async_rd_written", 32'(rd_written), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd6, 1'b0);
        tick();
        checkOutput("post_reset_word6", 32'(rd_data), 32'(0));
        applyStimulus(1'b1, 3'd7, 16'h7777, 3'd7, 1'b0);
        checkOutput("post_reset_wr_ready", 32'(wr_ready), 32'(1));
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd7, 1'b0);
        tick();
        checkOutput("post_reset_word7", 32'(rd_data), 32'h0000_7777);
        checkOutput("post_reset_written7", 32'(rd_written), 32'(1));

        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom),
                          ($urandom_range(0, 31) == 0));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 1'b0);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
